// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: shared FSM encoding, default widths and request-entry sizing
//   state_e  - bridge FSM states (2 bits)
//   entry_w  - width of a queued request {write, addr, wdata}
package apb_cmd_master_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;
  function automatic int entry_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction
endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: request/response handshake plus APB3 bus of the command master
//   req_*   - request offered to the bridge (req_ready returned)
//   rsp_*   - response returned by the bridge (rsp_ready consumed)
//   P*      - APB3 master outputs and slave returns
//   master  - bridge view; slave - requester/peripheral view
interface apb_cmd_master_if import apb_cmd_master_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_req_fifo.sv
// apb_req_fifo: synchronous request FIFO with registered full/empty
//   PCLK/PRESERN - clock, synchronous active-low reset
//   push_i/wdata_i - write strobe and entry (ignored when full)
//   pop_i/rdata_o  - read strobe and head entry (ignored when empty)
//   full_o/empty_o - registered status flags
module apb_req_fifo import apb_cmd_master_pkg::*; #(
  parameter int W = entry_w(DEF_ADDR_W, DEF_DATA_W),
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         PCLK,
  input  logic         PRESERN,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic full_q, empty_q, do_push, do_pop;
  assign do_push = push_i && !full_q;
  assign do_pop = pop_i && !empty_q;
  assign wp_d = wp_q + {{AW{1'b0}}, do_push};
  assign rp_d = rp_q + {{AW{1'b0}}, do_pop};
  // Pointers carry one extra MSB: equal low bits with differing MSB means full.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      wp_q <= '0;
      rp_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      empty_q <= wp_d == rp_d;
      full_q <= wp_d == {~rp_d[AW], rp_d[AW-1:0]};
    end
  end
  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end
  assign rdata_o = mem_q[rp_q[AW-1:0]];
  assign full_o = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB3 master bridge issuing single queued read/write transfers
//   PCLK    - bus clock
//   PRESERN - synchronous active-low reset
//   bus     - request/response handshake and APB3 signals (master modport)
module apb_cmd_master import apb_cmd_master_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic PCLK,
  input logic PRESERN,
  apb_cmd_master_if.master bus
);
  localparam int EW = entry_w(ADDR_W, DATA_W);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_e state_q, state_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] head;
  logic full, empty, pop, timed_out;
  apb_req_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .push_i  (bus.req_valid),
    .wdata_i ({bus.req_write, bus.req_addr, bus.req_wdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign timed_out = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    psel_d = psel_q;
    penable_d = penable_q;
    pwrite_d = pwrite_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d = rdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d = rsp_err_q;
    cnt_d = cnt_q;
    pop = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!empty) begin
        pop = 1'b1;
        psel_d = 1'b1;
        penable_d = 1'b0;
        pwrite_d = head[EW-1];
        paddr_d = head[DATA_W +: ADDR_W];
        pwdata_d = head[EW-1] ? head[DATA_W-1:0] : '0;
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: if (bus.PREADY || timed_out) begin
        psel_d = 1'b0;
        penable_d = 1'b0;
        rdata_d = (bus.PREADY && !pwrite_q) ? bus.PRDATA : '0;
        rsp_err_d = bus.PREADY ? bus.PSLVERR : 1'b1;
        rsp_valid_d = 1'b1;
        state_d = ST_RESP;
      end else begin
        cnt_d = (TIMEOUT > 0) ? cnt_q + 1'b1 : cnt_q;
      end
      ST_RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      state_q <= ST_IDLE;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.req_ready = !full;
  assign bus.PSEL = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE = pwrite_q;
  assign bus.PADDR = paddr_q;
  assign bus.PWDATA = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = rsp_err_q;
endmodule
